// File: rtl/dma_stream_out.sv
// dma_stream_out
// Streams a block of words out of a buffer (read through port B) onto a
// valid/ready stream. A transfer starts at startAddress and reads blockLength
// consecutive entries, wrapping modulo nrOfEntries. Reads are throttled so a
// 2-entry FIFO in front of the stream never overflows.
//
// Optional feature: define DMA_STREAM_OUT_LAST_EN to add streamLast, which is
// high with streamValid on the final word of a transfer.
//
// Ports
//   clock          sole clock, rising edge
//   nReset         asynchronous active-low reset
//   start          transfer request, sampled only in IDLE
//   startAddress   first buffer entry to read (latched on accept)
//   blockLength    number of words to stream, 0 allowed (latched on accept)
//   busy           high while not in IDLE
//   done           one-cycle pulse after the last handshake (or after a
//                  zero-length start)
//   bufferAddress  registered read address to buffer port B
//   bufferDataIn   buffer port B data, valid at the end of the address cycle
//   streamData     outgoing word (FIFO head)
//   streamValid    streamData holds a valid word
//   streamReady    consumer accepts the word this cycle
//   streamLast     (optional) final word of the transfer
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; done pulses from here for zero length
// STREAM | reads still to be issued; FIFO filling/draining
// DRAIN  | all reads issued; waiting for the last word's handshake

module dma_stream_out #(
    parameter int bitwidth    = 32,
    parameter int nrOfEntries = 512   // must be a power of two
) (
    input  logic                           clock,
    input  logic                           nReset,
    input  logic                           start,
    input  logic [$clog2(nrOfEntries)-1:0] startAddress,
    input  logic [$clog2(nrOfEntries):0]   blockLength,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(nrOfEntries)-1:0] bufferAddress,
    input  logic [bitwidth-1:0]            bufferDataIn,
    output logic [bitwidth-1:0]            streamData,
    output logic                           streamValid,
    input  logic                           streamReady
`ifdef DMA_STREAM_OUT_LAST_EN
    ,
    output logic                           streamLast
`endif
);

    localparam int AW = $clog2(nrOfEntries);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [LW-1:0]     reads_left;
    logic [LW-1:0]     words_left;
    logic [bitwidth-1:0] fifo_mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        fifo_count;
    logic              accept, issue, pop, last_hs, done_q;

    assign accept = (state == IDLE) && start;
    assign pop    = streamValid && streamReady;
    // The read completes within the cycle it is issued, so the only
    // occupancy to account for is the FIFO itself after this cycle's pop.
    assign issue   = (state == STREAM) && ((fifo_count != 2'd2) || pop);
    assign last_hs = pop && (words_left == LW'(1));

    // State register
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && (blockLength != '0)) state_nxt = STREAM;
            STREAM:  if (issue && (reads_left == LW'(1))) state_nxt = DRAIN;
            DRAIN:   if (last_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy        = (state != IDLE);
        streamValid = (fifo_count != 2'd0);
        streamData  = fifo_mem[rd_ptr];
        done        = done_q;
    end

`ifdef DMA_STREAM_OUT_LAST_EN
    assign streamLast = streamValid && (words_left == LW'(1));
`endif

    // Address and word counters
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            bufferAddress <= '0;
            reads_left    <= '0;
            words_left    <= '0;
            done_q        <= 1'b0;
        end else begin
            if (accept) begin
                bufferAddress <= startAddress;
                reads_left    <= blockLength;
                words_left    <= blockLength;
            end else begin
                if (issue) begin
                    bufferAddress <= bufferAddress + AW'(1);  // wraps at depth
                    reads_left    <= reads_left - LW'(1);
                end
                if (pop) words_left <= words_left - LW'(1);
            end
            done_q <= (accept && (blockLength == '0)) ||
                      ((state == DRAIN) && last_hs);
        end
    end

    // 2-entry output FIFO; a read issued this cycle is captured at this edge
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (issue) begin
                fifo_mem[wr_ptr] <= bufferDataIn;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({issue, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_stream_out.sv
module tb_dma_stream_out;

    localparam int BW = 32;
    localparam int N  = 512;
    localparam int AW = 9;

    logic          clock = 1'b0;
    logic          nReset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] startAddress = '0;
    logic [AW:0]   blockLength = '0;
    logic          busy, done;
    logic [AW-1:0] bufferAddress;
    logic [BW-1:0] bufferDataIn;
    logic [BW-1:0] streamData;
    logic          streamValid;
    logic          streamReady = 1'b0;
`ifdef DMA_STREAM_OUT_LAST_EN
    logic          streamLast;
`endif

    dma_stream_out #(.bitwidth(BW), .nrOfEntries(N)) dut (
        .clock(clock),
        .nReset(nReset),
        .start(start),
        .startAddress(startAddress),
        .blockLength(blockLength),
        .busy(busy),
        .done(done),
        .bufferAddress(bufferAddress),
        .bufferDataIn(bufferDataIn),
        .streamData(streamData),
        .streamValid(streamValid),
        .streamReady(streamReady)
`ifdef DMA_STREAM_OUT_LAST_EN
        ,
        .streamLast(streamLast)
`endif
    );

    always #5 clock = ~clock;

    // buffer[i] = i + 100, data valid within the address cycle
    assign bufferDataIn = {23'd0, bufferAddress} + 32'd100;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int vectors = 0;
    int miscompares = 0;
    int hs_count = 0;
    int done_count = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_block(input int addr, input int len);
        exp_t e;
        for (int k = 0; k < len; k++) begin
            e.data = 32'((addr + k) % N + 100);
            e.last = (k == len - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            step();
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (!nReset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_hold", streamValid, 1);
                chk("stall_data_hold", streamData, prev_data);
            end
            if (streamValid && streamReady) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_word: got %0d, expected no word", streamData);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("stream_data", streamData, mon_e.data);
`ifdef DMA_STREAM_OUT_LAST_EN
                    chk("stream_last", streamLast, mon_e.last);
`endif
                end
                hs_count++;
            end
            if (done) done_count++;
            prev_stall = streamValid && !streamReady;
            prev_data  = streamData;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, h0, max_out, issued, outs;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [AW-1:0] wrap_addr [4] = '{9'd510, 9'd511, 9'd0, 9'd1};

        // Reset state
        #12;
        chk("reset_outputs", {busy, done, streamValid, streamData, bufferAddress}, 0);
        @(posedge clock);
        #1 nReset = 1'b1;
        step();

        // Test 1: addr 5, len 4, ready held high
        d0 = done_count;
        streamReady = 1'b1;
        startAddress = 9'd5;
        blockLength = 10'd4;
        start = 1'b1;
        expect_block(5, 4);
        step();
        start = 1'b0;
        chk("t1_c1_valid", streamValid, 0);
        chk("t1_c1_addr", bufferAddress, 5);
        chk("t1_c1_busy", busy, 1);
        for (int c = 2; c <= 5; c++) begin
            step();
            chk("t1_valid_run", streamValid, 1);
            chk("t1_no_early_done", done, 0);
        end
        step();
        chk("t1_done", done, 1);
        chk("t1_busy_fall", busy, 0);
        chk("t1_valid_fall", streamValid, 0);
        step();
        chk("t1_done_single", done, 0);
        chk("t1_done_count", done_count - d0, 1);
        chk("t1_queue_empty", exp_q.size(), 0);

        // Test 2: wrap-around read addresses
        startAddress = 9'd510;
        blockLength = 10'd4;
        start = 1'b1;
        expect_block(510, 4);
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t2_read_addr", bufferAddress, wrap_addr[k]);
            step();
        end
        wait_idle(20);
        step();
        chk("t2_queue_empty", exp_q.size(), 0);

        // Test 3: ready toggling 1,0,0,1
        d0 = done_count;
        h0 = hs_count;
        max_out = 0;
        startAddress = 9'd40;
        blockLength = 10'd6;
        start = 1'b1;
        expect_block(40, 6);
        step();
        start = 1'b0;
        for (int c = 0; c < 80 && busy; c++) begin
            streamReady = pat[c % 4];
            step();
            issued = int'(9'(bufferAddress - 9'd40));
            outs = issued - (hs_count - h0);
            if (outs > max_out) max_out = outs;
        end
        chk("t3_idle", busy, 0);
        chk("t3_outstanding_le2", (max_out <= 2), 1);
        chk("t3_word_count", hs_count - h0, 6);
        streamReady = 1'b1;
        step();
        chk("t3_done_count", done_count - d0, 1);
        chk("t3_queue_empty", exp_q.size(), 0);

        // Test 4: zero length, then start while busy
        d0 = done_count;
        h0 = hs_count;
        startAddress = 9'd7;
        blockLength = 10'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_zero_done", done, 1);
        chk("t4_zero_busy", busy, 0);
        chk("t4_zero_valid", streamValid, 0);
        step();
        chk("t4_zero_done_single", done, 0);
        chk("t4_zero_done_count", done_count - d0, 1);
        startAddress = 9'd20;
        blockLength = 10'd3;
        start = 1'b1;
        expect_block(20, 3);
        step();
        startAddress = 9'd100;
        blockLength = 10'd5;
        step();
        start = 1'b0;
        wait_idle(20);
        step();
        chk("t4_ignored_start_words", hs_count - h0, 3);
        chk("t4_queue_empty", exp_q.size(), 0);

        // Test 5: reset after 2 of 8 words
        startAddress = 9'd0;
        blockLength = 10'd8;
        start = 1'b1;
        expect_block(0, 8);
        h0 = hs_count;
        step();
        start = 1'b0;
        for (int c = 0; c < 20 && (hs_count - h0) < 2; c++) step();
        chk("t5_two_words", hs_count - h0, 2);
        #2 nReset = 1'b0;
        #1;
        chk("t5_reset_outputs", {busy, done, streamValid, streamData, bufferAddress}, 0);
        exp_q.delete();
        @(posedge clock);
        #1 nReset = 1'b1;
        d0 = done_count;
        h0 = hs_count;
        repeat (10) step();
        chk("t5_no_words", hs_count - h0, 0);
        chk("t5_no_done", done_count - d0, 0);
        chk("t5_idle", busy, 0);

        // Test 6: length 3, last flag on the third word
        startAddress = 9'd300;
        blockLength = 10'd3;
        start = 1'b1;
        expect_block(300, 3);
        h0 = hs_count;
        step();
        start = 1'b0;
        wait_idle(20);
        step();
        chk("t6_word_count", hs_count - h0, 3);
        chk("t6_queue_empty", exp_q.size(), 0);
`ifdef DMA_STREAM_OUT_LAST_EN
        chk("t6_last_idle", streamLast, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
